// File: rtl/fp_align_pkg.sv
// Shared widths, stage payloads and IEEE helpers
// for the FP operand extract/align pipeline.
package fp_align_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN1_W  = 47;
  localparam int FP_MAN2_W  = 23;
  localparam int FP_TAG_W   = 5;
  localparam int FP_ALIGN_W = FP_MAN1_W + 1;
  localparam int FP_OUT_W   = FP_ALIGN_W + 2;
  localparam int FP_DIFF_W  = FP_EXP_W + 1;
  localparam int FP_N2_W    = 1 + FP_EXP_W + FP_MAN2_W;

  typedef struct packed {
    logic                  sign1;
    logic                  sign2;
    logic [FP_ALIGN_W-1:0] mant1;
    logic [FP_ALIGN_W-1:0] mant2;
    logic [FP_DIFF_W-1:0]  diff;
    logic                  swap;
    logic [FP_EXP_W-1:0]   exp_res;
    logic                  nan;
    logic                  inf;
    logic                  invalid;
    logic                  zero;
    logic                  res_zero;
    logic [FP_TAG_W-1:0]   tag;
  } align_a_t;

  typedef struct packed {
    logic [FP_TAG_W-1:0] tag;
    logic                sign1;
    logic                sign2;
    logic [FP_EXP_W-1:0] exp_res;
    logic [FP_OUT_W-1:0] mant1;
    logic [FP_OUT_W-1:0] mant2;
    logic                sticky;
    logic                swap;
    logic                nan;
    logic                inf;
    logic                invalid;
    logic                zero;
    logic                res_zero;
  } align_b_t;

  function automatic logic fp_is_nan(
    input logic [FP_N2_W-1:0] v
  );
    return (&v[FP_N2_W-2 -: FP_EXP_W])
        && (|v[FP_MAN2_W-1:0]);
  endfunction

  function automatic logic fp_is_inf(
    input logic [FP_N2_W-1:0] v
  );
    return (&v[FP_N2_W-2 -: FP_EXP_W])
        && !(|v[FP_MAN2_W-1:0]);
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Saturating right shifter; collects every bit
// pushed below the LSB into a sticky flag.
module fp_align_shifter #(
  parameter int W    = 50,
  parameter int SH_W = 9
) (
  input  logic [W-1:0]    i_data,
  input  logic [SH_W-1:0] i_shamt,
  output logic [W-1:0]    o_data,
  output logic            o_sticky
);

  logic [2*W-1:0] w_wide;

  always_comb begin
    w_wide   = {i_data, {W{1'b0}}} >> i_shamt;
    o_data   = w_wide[2*W-1:W];
    o_sticky = |w_wide[W-1:0];
    if (int'(i_shamt) >= W) begin
      o_data   = '0;
      o_sticky = |i_data;
    end
  end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage FP operand classify/align pipeline:
// stage A compares exponents, stage B shifts.
module fp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MAN1_W = FP_MAN1_W,
  parameter int MAN2_W = FP_MAN2_W,
  parameter int TAG_W  = FP_TAG_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    add_sub,
  input  logic [EXP_W-1:0]        num1_exp,
  input  logic [MAN1_W-1:0]       num1_mant,
  input  logic                    num1_sign,
  input  logic                    num1_is_nan,
  input  logic                    num1_is_inf,
  input  logic                    num1_is_zero,
  input  logic [EXP_W+MAN2_W:0]   num2,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    sign1,
  output logic                    sign2,
  output logic [EXP_W-1:0]        exp_res,
  output logic [MAN1_W+2:0]       mant1_aligned,
  output logic [MAN1_W+2:0]       mant2_aligned,
  output logic                    sticky,
  output logic                    swap,
  output logic                    nan,
  output logic                    inf,
  output logic                    invalid,
  output logic                    zero,
  output logic                    res_zero
);

  localparam int ALIGN_W = MAN1_W + 1;
  localparam int OUT_W   = ALIGN_W + 2;
  localparam int DIFF_W  = EXP_W + 1;

  logic               r_a_valid;
  logic               r_b_valid;
  align_a_t           r_a;
  align_b_t           r_b;

  logic               w_a_ready;
  logic               w_b_ready;
  align_a_t           w_a;
  align_b_t           w_b;

  logic [EXP_W-1:0]   w_e2_raw;
  logic [MAN2_W-1:0]  w_f2;
  logic               w_zero1;
  logic               w_zero2;
  logic               w_nan2;
  logic               w_inf2;
  logic [ALIGN_W-1:0] w_m1;
  logic [ALIGN_W-1:0] w_m2;
  logic [DIFF_W-1:0]  w_e1;
  logic [DIFF_W-1:0]  w_e2;

  logic [ALIGN_W-1:0] w_small;
  logic [OUT_W-1:0]   w_shifted;
  logic               w_sticky;

  assign w_e2_raw = num2[MAN2_W +: EXP_W];
  assign w_f2     = num2[MAN2_W-1:0];
  assign w_nan2   = fp_is_nan(num2);
  assign w_inf2   = fp_is_inf(num2);

  // Subnormals run at effective exponent 1 with
  // hidden bit 0; true zeros collapse to 0/0.
  always_comb begin
    w_zero1 = num1_is_zero
           || (num1_exp == '0 && num1_mant == '0);
    w_zero2 = (w_e2_raw == '0) && (w_f2 == '0);
    w_m1 = '0;
    w_e1 = '0;
    w_m2 = '0;
    w_e2 = '0;
    if (!w_zero1) begin
      w_m1 = {num1_exp != '0, num1_mant};
      w_e1 = (num1_exp == '0) ? DIFF_W'(1)
                              : {1'b0, num1_exp};
    end
    if (!w_zero2) begin
      w_m2 = ALIGN_W'({w_e2_raw != '0, w_f2})
          << (MAN1_W - MAN2_W);
      w_e2 = (w_e2_raw == '0) ? DIFF_W'(1)
                              : {1'b0, w_e2_raw};
    end
  end

  always_comb begin
    w_a         = '0;
    w_a.sign1   = num1_sign;
    w_a.sign2   = num2[EXP_W+MAN2_W] ^ add_sub;
    w_a.mant1   = w_m1;
    w_a.mant2   = w_m2;
    w_a.tag     = in_tag;
    w_a.invalid = num1_is_inf && w_inf2
               && (w_a.sign1 != w_a.sign2);
    w_a.nan     = num1_is_nan || w_nan2 || w_a.invalid;
    w_a.inf     = (num1_is_inf || w_inf2) && !w_a.nan;
    w_a.zero    = w_zero1 || w_zero2;
    if (w_e2 > w_e1) begin
      w_a.swap    = 1'b1;
      w_a.diff    = w_e2 - w_e1;
      w_a.exp_res = w_e2[EXP_W-1:0];
    end else begin
      w_a.swap    = 1'b0;
      w_a.diff    = w_e1 - w_e2;
      w_a.exp_res = w_e1[EXP_W-1:0];
    end
    w_a.res_zero = (w_e1 == w_e2) && (w_m1 == w_m2)
                && (w_a.sign1 != w_a.sign2)
                && !w_a.nan
                && !num1_is_inf && !w_inf2;
    if (w_a.res_zero) w_a.exp_res = '0;
  end

  assign w_small = r_a.swap ? r_a.mant1 : r_a.mant2;

  fp_align_shifter #(
    .W    (OUT_W),
    .SH_W (DIFF_W)
  ) u_shifter (
    .i_data   ({w_small, 2'b00}),
    .i_shamt  (r_a.diff),
    .o_data   (w_shifted),
    .o_sticky (w_sticky)
  );

  always_comb begin
    w_b          = '0;
    w_b.tag      = r_a.tag;
    w_b.sign1    = r_a.sign1;
    w_b.sign2    = r_a.sign2;
    w_b.exp_res  = r_a.exp_res;
    w_b.sticky   = w_sticky;
    w_b.swap     = r_a.swap;
    w_b.nan      = r_a.nan;
    w_b.inf      = r_a.inf;
    w_b.invalid  = r_a.invalid;
    w_b.zero     = r_a.zero;
    w_b.res_zero = r_a.res_zero;
    w_b.mant1    = r_a.swap ? w_shifted
                            : {r_a.mant1, 2'b00};
    w_b.mant2    = r_a.swap ? {r_a.mant2, 2'b00}
                            : w_shifted;
  end

  assign w_b_ready = !r_b_valid || out_ready;
  assign w_a_ready = !r_a_valid || w_b_ready;
  assign in_ready  = !flush && w_a_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
    end else if (flush) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
    end else begin
      if (w_b_ready) begin
        r_b_valid <= r_a_valid;
        if (r_a_valid) r_b <= w_b;
      end
      if (w_a_ready) begin
        r_a_valid <= in_valid;
        if (in_valid) r_a <= w_a;
      end
    end
  end

  assign out_valid     = r_b_valid;
  assign out_tag       = r_b.tag;
  assign sign1         = r_b.sign1;
  assign sign2         = r_b.sign2;
  assign exp_res       = r_b.exp_res;
  assign mant1_aligned = r_b.mant1;
  assign mant2_aligned = r_b.mant2;
  assign sticky        = r_b.sticky;
  assign swap          = r_b.swap;
  assign nan           = r_b.nan;
  assign inf           = r_b.inf;
  assign invalid       = r_b.invalid;
  assign zero          = r_b.zero;
  assign res_zero      = r_b.res_zero;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed bench for fp_align_pipe with a value-level
// reference model and a per-cycle output scoreboard.
module tb_fp_align_pipe;

  typedef struct packed {
    logic [7:0]  e1;
    logic [46:0] m1;
    logic        s1;
    logic        isnan;
    logic        isinf;
    logic        iszero;
    logic [31:0] n2;
    logic        addsub;
    logic [4:0]  tag;
  } in_t;

  typedef struct packed {
    logic [4:0]  tag;
    logic        s1;
    logic        s2;
    logic [7:0]  er;
    logic [49:0] a1;
    logic [49:0] a2;
    logic        st;
    logic        sw;
    logic        nan;
    logic        inf;
    logic        inv;
    logic        zero;
    logic        rz;
  } res_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  in_t  cur;

  logic        in_ready, out_valid;
  logic        add_sub;
  logic [7:0]  num1_exp;
  logic [46:0] num1_mant;
  logic        num1_sign, num1_is_nan;
  logic        num1_is_inf, num1_is_zero;
  logic [31:0] num2;
  logic [4:0]  in_tag, out_tag;
  logic        sign1, sign2;
  logic [7:0]  exp_res;
  logic [49:0] mant1_aligned, mant2_aligned;
  logic        sticky, swap, nan, inf;
  logic        invalid, zero, res_zero;

  int   n_chk = 0;
  int   n_fail = 0;
  res_t q[$];
  int   seen[$];

  always #5 clk = ~clk;

  assign num1_exp     = cur.e1;
  assign num1_mant    = cur.m1;
  assign num1_sign    = cur.s1;
  assign num1_is_nan  = cur.isnan;
  assign num1_is_inf  = cur.isinf;
  assign num1_is_zero = cur.iszero;
  assign num2         = cur.n2;
  assign add_sub      = cur.addsub;
  assign in_tag       = cur.tag;

  fp_align_pipe #(
    .EXP_W (8), .MAN1_W (47),
    .MAN2_W (23), .TAG_W (5)
  ) dut (
    .clk (clk), .reset (reset), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready),
    .add_sub (add_sub),
    .num1_exp (num1_exp), .num1_mant (num1_mant),
    .num1_sign (num1_sign),
    .num1_is_nan (num1_is_nan),
    .num1_is_inf (num1_is_inf),
    .num1_is_zero (num1_is_zero),
    .num2 (num2), .in_tag (in_tag),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_tag (out_tag),
    .sign1 (sign1), .sign2 (sign2),
    .exp_res (exp_res),
    .mant1_aligned (mant1_aligned),
    .mant2_aligned (mant2_aligned),
    .sticky (sticky), .swap (swap),
    .nan (nan), .inf (inf),
    .invalid (invalid), .zero (zero),
    .res_zero (res_zero)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Operands as integer significand * 2^exp; the
  // aligned value is floor(sig*4 / 2^diff).
  function automatic res_t model(input in_t x);
    res_t        r;
    logic [63:0] m1, m2, g, sh;
    int          e1, e2, d;
    logic        z1, z2, nan2, inf2;
    logic [7:0]  x2;
    logic [22:0] f2;
    r  = '0;
    x2 = x.n2[30:23];
    f2 = x.n2[22:0];
    z1 = x.iszero || (x.e1 == 0 && x.m1 == 0);
    z2 = (x2 == 0) && (f2 == 0);
    m1 = z1 ? 64'd0 : {16'd0, x.e1 != 0, x.m1};
    e1 = z1 ? 0 : (x.e1 == 0 ? 1 : int'(x.e1));
    m2 = z2 ? 64'd0 : ({40'd0, x2 != 0, f2} << 24);
    e2 = z2 ? 0 : (x2 == 0 ? 1 : int'(x2));
    nan2 = (x2 == 8'hFF) && (f2 != 0);
    inf2 = (x2 == 8'hFF) && (f2 == 0);
    r.tag  = x.tag;
    r.s1   = x.s1;
    r.s2   = x.n2[31] ^ x.addsub;
    r.inv  = x.isinf && inf2 && (r.s1 != r.s2);
    r.nan  = x.isnan || nan2 || r.inv;
    r.inf  = (x.isinf || inf2) && !r.nan;
    r.zero = z1 || z2;
    r.sw   = e2 > e1;
    d      = r.sw ? e2 - e1 : e1 - e2;
    r.er   = 8'(r.sw ? e2 : e1);
    g      = (r.sw ? m1 : m2) << 2;
    if (d >= 50) begin
      sh   = 0;
      r.st = g != 0;
    end else begin
      sh   = g >> d;
      r.st = (sh << d) != g;
    end
    r.a1 = 50'(r.sw ? sh : m1 << 2);
    r.a2 = 50'(r.sw ? m2 << 2 : sh);
    r.rz = (e1 == e2) && (m1 == m2) && (r.s1 != r.s2)
        && !r.nan && !x.isinf && !inf2;
    if (r.rz) r.er = 0;
    return r;
  endfunction

  function automatic in_t mk(
    input logic [7:0] e1, input logic [46:0] m1,
    input logic s1, input logic isnan,
    input logic isinf, input logic iszero,
    input logic [31:0] n2, input logic addsub,
    input logic [4:0] tag);
    in_t x;
    x.e1 = e1; x.m1 = m1; x.s1 = s1;
    x.isnan = isnan; x.isinf = isinf;
    x.iszero = iszero; x.n2 = n2;
    x.addsub = addsub; x.tag = tag;
    return x;
  endfunction

  task automatic cmp(input res_t e);
    chk("o_tag",  64'(out_tag),       64'(e.tag));
    chk("o_s1",   64'(sign1),         64'(e.s1));
    chk("o_s2",   64'(sign2),         64'(e.s2));
    chk("o_exp",  64'(exp_res),       64'(e.er));
    chk("o_m1",   64'(mant1_aligned), 64'(e.a1));
    chk("o_m2",   64'(mant2_aligned), 64'(e.a2));
    chk("o_stk",  64'(sticky),        64'(e.st));
    chk("o_swap", 64'(swap),          64'(e.sw));
    chk("o_flag",
        64'({nan, inf, invalid, zero, res_zero}),
        64'({e.nan, e.inf, e.inv, e.zero, e.rz}));
  endtask

  // Scoreboard: the front entry must be on the outputs
  // every valid cycle, which also proves stall stability.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("o_unexpected", 64'(q.size()), 64'd1);
        end else begin
          cmp(q[0]);
          if (out_ready) begin
            seen.push_back(int'(out_tag));
            void'(q.pop_front());
          end
        end
      end
      if (flush) q.delete();
      if (in_valid && in_ready) q.push_back(model(cur));
    end
  end

  task automatic send(input in_t x);
    int n;
    n = 0;
    cur = x;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run1(input in_t x);
    out_ready = 1'b1;
    send(x);
    chk("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_2cyc", 64'(out_valid), 64'd1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_m1"}, 64'(mant1_aligned), 64'd0);
    chk({nm, "_m2"}, 64'(mant2_aligned), 64'd0);
    chk({nm, "_misc"},
        64'({out_valid, out_tag, sign1, sign2,
             exp_res, sticky, swap, nan, inf,
             invalid, zero, res_zero}), 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] bp_n2 [4];
    bp_n2[0] = 32'h3F800000; bp_n2[1] = 32'hC0400000;
    bp_n2[2] = 32'h00000005; bp_n2[3] = 32'h41200000;
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    cur = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_idle("reset");

    run1(mk(8'h81, 0, 0, 0, 0, 0, 32'h3F800000, 0, 1));
    chk("basic_m1", 64'(mant1_aligned[49:2]),
        64'h8000_0000_0000);
    chk("basic_m2", 64'(mant2_aligned[49:2]),
        64'h2000_0000_0000);
    chk("basic_gr", 64'(mant2_aligned[1:0]), 64'd0);
    chk("basic_stk", 64'(sticky), 64'd0);
    chk("basic_exp", 64'(exp_res), 64'h81);
    chk("basic_swap", 64'(swap), 64'd0);

    run1(mk(8'hC0, 0, 0, 0, 0, 0, 32'h3F800001, 0, 2));
    chk("sat_m2", 64'(mant2_aligned), 64'd0);
    chk("sat_stk", 64'(sticky), 64'd1);
    chk("sat_exp", 64'(exp_res), 64'hC0);

    run1(mk(8'h7F, 0, 0, 0, 0, 0, 32'h3F800000, 1, 3));
    chk("cancel_rz", 64'(res_zero), 64'd1);
    chk("cancel_exp", 64'(exp_res), 64'd0);

    run1(mk(8'h00, 47'h1, 0, 0, 0, 0,
            32'h00800000, 0, 4));
    chk("subn_exp", 64'(exp_res), 64'd1);
    chk("subn_rz", 64'(res_zero), 64'd0);
    chk("subn_m1", 64'(mant1_aligned), 64'h4);
    chk("subn_m2", 64'(mant2_aligned[49:2]),
        64'h8000_0000_0000);

    run1(mk(8'hFF, 0, 0, 0, 1, 0, 32'h7F800000, 1, 5));
    chk("infinv_flags", 64'({invalid, nan, inf}),
        64'b110);

    run1(mk(8'h80, 0, 0, 0, 0, 0, 32'h7FC00000, 0, 6));
    chk("qnan_flags", 64'({invalid, nan}), 64'b01);

    run1(mk(8'h80, 0, 0, 0, 0, 0, 32'h7F800000, 0, 7));
    chk("inf_flags", 64'({invalid, nan, inf}),
        64'b001);

    run1(mk(8'h7E, 0, 0, 0, 0, 0, 32'h40000000, 0, 8));
    chk("swap_swap", 64'(swap), 64'd1);
    chk("swap_exp", 64'(exp_res), 64'h80);
    chk("swap_m1", 64'(mant1_aligned[49:2]),
        64'h2000_0000_0000);

    run1(mk(8'h9A, 0, 0, 0, 0, 0, 32'h3F800003, 0, 9));
    chk("stk27_m2", 64'(mant2_aligned), 64'h400001);
    chk("stk27_stk", 64'(sticky), 64'd1);

    run1(mk(8'hB0, 0, 0, 0, 0, 0, 32'h3F800000, 0, 10));
    chk("d49_m2", 64'(mant2_aligned), 64'h1);
    chk("d49_stk", 64'(sticky), 64'd0);

    run1(mk(8'hB1, 0, 0, 0, 0, 0, 32'h3F800000, 0, 11));
    chk("d50_m2", 64'(mant2_aligned), 64'd0);
    chk("d50_stk", 64'(sticky), 64'd1);

    @(posedge clk); #1;
    seen.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int t = 1; t <= 4; t++) begin
          send(mk(8'h80 + 8'(t), 47'(t * 977), t[0],
                  0, 0, 0, bp_n2[t-1], t[1], 5'(t)));
          if (t == 2)
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_hold_tag", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 30 && seen.size() < 4; i++)
      @(posedge clk);
    #1;
    chk("bp_count", 64'(seen.size()), 64'd4);
    for (int i = 0; i < seen.size() && i < 4; i++)
      chk("bp_order", 64'(seen[i]), 64'(i + 1));

    @(posedge clk); #1;
    seen.delete();
    out_ready = 1'b0;
    send(mk(8'h85, 0, 0, 0, 0, 0, 32'h3F000000, 0, 12));
    send(mk(8'h70, 0, 1, 0, 0, 0, 32'h3F800000, 0, 13));
    flush = 1'b1;
    cur = mk(8'h90, 47'h55, 0, 0, 0, 0,
             32'h41000001, 1, 14);
    in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flush_lat_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush_lat_2cyc", 64'(out_valid), 64'd1);
    chk("flush_tag", 64'(out_tag), 64'd14);
    @(posedge clk); #1;
    chk("flush_seen", 64'(seen.size()), 64'd1);

    out_ready = 1'b0;
    send(mk(8'h82, 0, 0, 0, 0, 0, 32'hBF800000, 0, 15));
    send(mk(8'h83, 0, 0, 0, 0, 0, 32'h3F800000, 1, 16));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_idle("midrst");
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
